// File: rtl/uio_prbs_endpoint_if.sv
`default_nettype none
// ============================================================================
// Module : uio_prbs_endpoint_if
// Brief  : User-IO request/response port pair between endpoint and black box.
// Rev    : 1.0
// ============================================================================
interface uio_prbs_endpoint_if #(
    parameter int UIO_PORTS_WIDTH = 128
);
    logic                       uio_rq_vld;
    logic [UIO_PORTS_WIDTH-1:0] uio_rq_data;
    logic                       uio_rq_afull;
    logic                       uio_rs_vld;
    logic [UIO_PORTS_WIDTH-1:0] uio_rs_data;
    logic                       uio_rs_afull;

    // master = personality endpoint, slave = black box side
    modport master (
        output uio_rq_vld, uio_rq_data, uio_rs_afull,
        input  uio_rq_afull, uio_rs_vld, uio_rs_data
    );
    modport slave (
        input  uio_rq_vld, uio_rq_data, uio_rs_afull,
        output uio_rq_afull, uio_rs_vld, uio_rs_data
    );
endinterface
`default_nettype wire

// File: rtl/uio_prbs_endpoint.sv
`default_nettype none
// ============================================================================
// Module : uio_prbs_endpoint
// Brief  : PRBS-31 loopback traffic generator/checker for one user-IO port.
//          Optional checker resync enabled by defining UIO_PRBS_RESYNC_EN.
// Rev    : 1.0
// ============================================================================
module uio_prbs_endpoint #(
    parameter int          UIO_PORTS_WIDTH = 128,
    parameter logic [30:0] SEED            = 31'h7FFFFFFF,
    parameter int          TIMEOUT         = 65535
) (
    input  wire logic                  clk_per,
    input  wire logic                  reset_per_n,
    input  wire logic                  i_start,
    input  wire logic [31:0]           i_word_cnt,
    uio_prbs_endpoint_if.master        uio,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_timeout,
    output logic [31:0]                o_tx_cnt,
    output logic [31:0]                o_rx_cnt,
    output logic [15:0]                o_err_cnt
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef logic [UIO_PORTS_WIDTH-1:0] word_t;

    // Word bit i is the i-th generated bit; returns {next_state, word}.
    function automatic logic [UIO_PORTS_WIDTH+30:0] prbs_word(input logic [30:0] s_in);
        logic [30:0] s;
        word_t       w;
        logic        b;
        s = s_in;
        w = '0;
        for (int i = 0; i < UIO_PORTS_WIDTH; i++) begin
            b    = s[30] ^ s[27];
            w[i] = b;
            s    = {s[29:0], b};
        end
        return {s, w};
    endfunction

    logic [1:0]  state_q, state_d;
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [31:0] tx_cnt_q, tx_cnt_d;
    logic [31:0] rx_cnt_q, rx_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [31:0] idle_q, idle_d;
    logic [2:0]  miss_q, miss_d;
    logic [30:0] gen_q, gen_d, chk_q, chk_d;
    logic        rq_vld_q, rq_vld_d;
    word_t       rq_data_q, rq_data_d;
    logic        busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;

    logic        start_acc, tx_en, rx_en, mismatch;
    logic [31:0] cur_word_cnt, cur_tx_cnt;
    logic [30:0] gen_src, gen_nxt, chk_nxt;
    word_t       gen_word, chk_word;

    always_comb begin
        state_d   = state_q;
        word_cnt_d = word_cnt_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        err_cnt_d = err_cnt_q;
        idle_d    = idle_q;
        miss_d    = miss_q;
        gen_d     = gen_q;
        chk_d     = chk_q;
        rq_data_d = rq_data_q;
        timeout_d = timeout_q;

        start_acc    = i_start && (state_q == S_IDLE || state_q == S_DONE);
        cur_word_cnt = start_acc ? i_word_cnt : word_cnt_q;
        cur_tx_cnt   = start_acc ? 32'd0 : tx_cnt_q;
        gen_src      = start_acc ? SEED : gen_q;
        {gen_nxt, gen_word} = prbs_word(gen_src);
        {chk_nxt, chk_word} = prbs_word(chk_q);

        // The start cycle itself may issue the first word.
        tx_en    = (start_acc || state_q == S_RUN) && !uio.uio_rq_afull
                   && (cur_tx_cnt < cur_word_cnt);
        rq_vld_d = tx_en;
        if (tx_en) begin
            rq_data_d = gen_word;
            gen_d     = gen_nxt;
            tx_cnt_d  = cur_tx_cnt + 32'd1;
        end

        rx_en    = (state_q == S_RUN || state_q == S_DRAIN) && uio.uio_rs_vld
                   && (rx_cnt_q < word_cnt_q);
        mismatch = rx_en && (uio.uio_rs_data != chk_word);
        if (rx_en) begin
            rx_cnt_d = rx_cnt_q + 32'd1;
            chk_d    = chk_nxt;
            miss_d   = 3'd0;
            if (mismatch) begin
                if (err_cnt_q != 16'hFFFF) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end
`ifdef UIO_PRBS_RESYNC_EN
                if (miss_q == 3'd3) begin
                    for (int k = 0; k < 31; k++) begin
                        chk_d[k] = uio.uio_rs_data[UIO_PORTS_WIDTH-1-k];
                    end
                    miss_d = 3'd0;
                end else begin
                    miss_d = miss_q + 3'd1;
                end
`else
                miss_d = miss_q;
`endif
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_acc) begin
                    state_d    = S_RUN;
                    word_cnt_d = i_word_cnt;
                    tx_cnt_d   = tx_en ? 32'd1 : 32'd0;
                    rx_cnt_d   = 32'd0;
                    err_cnt_d  = 16'd0;
                    timeout_d  = 1'b0;
                    idle_d     = 32'd0;
                    miss_d     = 3'd0;
                    chk_d      = SEED;
                    if (!tx_en) begin
                        gen_d = SEED;
                    end
                end
            end
            S_RUN: begin
                idle_d = 32'd0;
                if (tx_cnt_q == word_cnt_q) begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                idle_d = rx_en ? 32'd0 : idle_q + 32'd1;
                if (rx_cnt_q == word_cnt_q) begin
                    state_d = S_DONE;
                end else if (!rx_en && idle_q == 32'(TIMEOUT - 1)) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_per or negedge reset_per_n) begin
        if (!reset_per_n) begin
            state_q    <= S_IDLE;
            word_cnt_q <= 32'd0;
            tx_cnt_q   <= 32'd0;
            rx_cnt_q   <= 32'd0;
            err_cnt_q  <= 16'd0;
            idle_q     <= 32'd0;
            miss_q     <= 3'd0;
            gen_q      <= SEED;
            chk_q      <= SEED;
            rq_vld_q   <= 1'b0;
            rq_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            err_cnt_q  <= err_cnt_d;
            idle_q     <= idle_d;
            miss_q     <= miss_d;
            gen_q      <= gen_d;
            chk_q      <= chk_d;
            rq_vld_q   <= rq_vld_d;
            rq_data_q  <= rq_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign uio.uio_rq_vld   = rq_vld_q;
    assign uio.uio_rq_data  = rq_data_q;
    assign uio.uio_rs_afull = 1'b0;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_timeout        = timeout_q;
    assign o_tx_cnt         = tx_cnt_q;
    assign o_rx_cnt         = rx_cnt_q;
    assign o_err_cnt        = err_cnt_q;

endmodule
`default_nettype wire

// File: doc/uio_prbs_endpoint.md
# uio_prbs_endpoint

Personality-side traffic endpoint for one user-IO port pair of the user-IO black box. It generates a PRBS-31 word stream onto the request side (`uio_rq_*`) under almost-full flow control. It checks the stream returning on the response side (`uio_rs_*`) against an independent PRBS-31 reference. It reports transmit, receive and error counts for loopback link testing over the Aurora links.

## Interface
Parameters:
- `UIO_PORTS_WIDTH`, 128: data word width; fixed at 128 for the PRBS mapping below.
- `SEED`, 31'h7FFFFFFF: nonzero initial LFSR state for both generator and checker.
- `TIMEOUT`, 65535: drain-phase idle-cycle limit.

Ports:
- `clk_per` in 1: personality clock; single clock domain.
- `reset_per_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: pulse; begins a test run.
- `i_word_cnt` in 32: number of words to send and expect; sampled on accepted `i_start`.
- `uio_rq_vld` out 1: request word valid.
- `uio_rq_data` out 128: request PRBS word.
- `uio_rq_afull` in 1: black box request path almost full.
- `uio_rs_vld` in 1: response word valid.
- `uio_rs_data` in 128: response word.
- `uio_rs_afull` out 1: always 0; the checker accepts every cycle.
- `o_busy` out 1: state is RUN or DRAIN.
- `o_done` out 1: state is DONE.
- `o_timeout` out 1: the run ended by drain timeout.
- `o_tx_cnt` out 32: words sent this run.
- `o_rx_cnt` out 32: words received this run.
- `o_err_cnt` out 16: mismatching words; saturates at 16'hFFFF.

## Operation
PRBS-31 definition:
- Polynomial x^31+x^28+1.
- Each step produces one bit `b = s[30]^s[27]`, then the state updates to `s = {s[29:0], b}`.
- One word is 128 consecutive steps. Word bit i is the i-th bit produced, so bit 0 is produced first.
- After a word, the state satisfies `s[k] = word[127-k]`.

FSM states are IDLE, RUN, DRAIN and DONE. Reset places the FSM in IDLE.
- IDLE or DONE, with `i_start`=1: go to RUN. On this transition:
  - latch `i_word_cnt`;
  - clear all counters and `o_timeout`;
  - load both LFSRs with `SEED`.
- `i_start` in RUN or DRAIN is ignored.
- RUN:
  - Each cycle with `uio_rq_afull`=0 and `tx_cnt` < `word_cnt`, the next cycle drives `uio_rq_vld`=1 with the next generator word, and `tx_cnt` increments.
  - When `tx_cnt` reaches `word_cnt`, go to DRAIN.
  - `word_cnt`=0: the FSM passes through RUN and DRAIN with no traffic and goes straight to DONE.
- RUN and DRAIN, receive side:
  - Each `uio_rs_vld`=1 with `rx_cnt` < `word_cnt` is compared with the checker word.
  - `rx_cnt` increments, and the checker advances 128 steps.
  - On mismatch, `err_cnt` increments (saturating).
  - `uio_rs_vld` in IDLE or DONE, or with `rx_cnt` == `word_cnt`, is ignored.
- DRAIN:
  - Go to DONE once `rx_cnt` == `word_cnt`.
  - The idle counter resets on every received word.
  - If the idle counter reaches `TIMEOUT` cycles with no received word, set `o_timeout`=1 and go to DONE.
- DONE holds the counters until the next `i_start`.

## Timing
- Reset values of all outputs are 0. The LFSRs reset to `SEED`.
- All outputs are registered. `uio_rs_afull` is constant 0.
- `i_start` sampled at cycle t: `o_busy`=1 at t+1. The first `uio_rq_vld` is at t+1 if `uio_rq_afull`=0 at t.
- `uio_rq_afull` sampled high at cycle t means `uio_rq_vld`=0 at t+1. At most one word is issued after afull rises.
- Back-to-back: with afull held low, one word is sent per cycle with no bubbles.
- A response word at cycle t updates `o_rx_cnt`/`o_err_cnt` at t+1.
- If the last word arrives at t, `o_done`=1 at t+2.
- Simultaneous transmit and receive in the same cycle are independent.
- `reset_per_n` asserted mid-run aborts immediately. All outputs return to 0 and the FSM returns to IDLE.

## Configuration
- `UIO_PRBS_RESYNC_EN` defined:
  - After 4 consecutive mismatching words, the checker reloads its state from the received word: `s[k] = uio_rs_data[127-k]`.
  - The next word is then checked against the continuation from that state.
  - The consecutive-mismatch count clears on any match and on the reload itself.
  - Mismatches still count in `o_err_cnt`.
- Not defined: the checker never resyncs. A dropped or inserted word makes every later word mismatch.

## Test plan
- **Direct loopback:** `uio_rq` connected to `uio_rs` with a 3-cycle delay, `i_word_cnt`=1000. Required: `o_tx_cnt`=`o_rx_cnt`=1000, `o_err_cnt`=0, `o_done`=1, `o_timeout`=0.
- **Flow control:** `uio_rq_afull` toggled high 5 of every 8 cycles, `i_word_cnt`=64. Required: `uio_rq_vld` never high the cycle after afull is high; 64 words sent in sequence; `o_err_cnt`=0.
- **Single-bit error:** bit 77 of word 10 flipped in the loopback. Required: `o_err_cnt`=1 and `o_rx_cnt`=1000.
- **Dropped word:** word 20 of 100 dropped. Required: `o_timeout`=1 after 65535 idle cycles, with `o_rx_cnt`=99. Without `UIO_PRBS_RESYNC_EN`, `o_err_cnt`=79. With it, `o_err_cnt`=4.
- **Zero length, restart, and reset mid-run:**
  - `i_word_cnt`=0: `o_done`=1 with no `uio_rq_vld`.
  - A second `i_start` from DONE clears the counters.
  - `reset_per_n` dropped after 50 of 200 words: all outputs go to 0 asynchronously and the FSM returns to IDLE.
